// File: rtl/coil_driver_if.sv
// Decoder-to-coil-driver bundle plus the gate drive outputs.
//
// Handshake: there is no back-pressure on this link. meta_valid is a
// one-cycle strobe qualifying meta; the driver is always ready and
// samples it on the CLK_IN edge where it is high. scan_active and
// polarity are level signals, sampled every edge. The outputs are all
// registered. state_dbg exposes the FSM state register (IDLE reads 0).
interface coil_driver_if;
  logic       scan_active;
  logic       polarity;
  logic [3:0] meta;
  logic       meta_valid;
  logic       HS_A;
  logic       LS_A;
  logic       HS_B;
  logic       LS_B;
  logic       driving;
  logic       fault;
  logic [2:0] state_dbg;

  // Decoder side (drives the requests, observes the bridge).
  modport master (
    output scan_active, polarity, meta, meta_valid,
    input  HS_A, LS_A, HS_B, LS_B, driving, fault, state_dbg
  );

  // Coil driver side.
  modport slave (
    input  scan_active, polarity, meta, meta_valid,
    output HS_A, LS_A, HS_B, LS_B, driving, fault, state_dbg
  );
endinterface

// File: rtl/coil_driver.sv
// H-bridge gate controller for the scan-loop coil.
// Inserts dead time on every polarity change, chops the high side with a
// 16-slot PWM whose duty is the captured amplitude code, holds the
// opposite low side on continuously (slow decay), and latches a fault
// when one polarity is held longer than MAX_HOLD_MS.
module coil_driver #(
  parameter int DEAD_CYC     = 20,
  parameter int PWM_DIV      = 4,
  parameter int TICKS_PER_MS = 10000,
  parameter int MAX_HOLD_MS  = 50
) (
  input  logic         CLK_IN,
  input  logic         rst,
  coil_driver_if.slave bus
);

  localparam int DEAD_W = $clog2(DEAD_CYC + 1);
  localparam int PRE_W  = $clog2(PWM_DIV + 1);
  localparam int MS_W   = $clog2(TICKS_PER_MS + 1);
  localparam int HOLD_W = $clog2(MAX_HOLD_MS + 1);

  // Terminal values: each counter is compared against its last value so
  // it never has to count past the parameter itself.
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYC - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PWM_DIV - 1);
  localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(TICKS_PER_MS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD_MS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEAD      = 3'd1,
    DRIVE_POS = 3'd2,
    DRIVE_NEG = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t              state_q,  state_d;
  logic                target_q, target_d;
  logic [DEAD_W-1:0]   dead_q,   dead_d;
  logic [3:0]          amp_q,    amp_d;
  logic [PRE_W-1:0]    pre_q,    pre_d;
  logic [3:0]          slot_q,   slot_d;
  logic [MS_W-1:0]     ms_q,     ms_d;
  logic [HOLD_W-1:0]   hold_q,   hold_d;

  logic hs_a_q, hs_a_d;
  logic ls_a_q, ls_a_d;
  logic hs_b_q, hs_b_d;
  logic ls_b_q, ls_b_d;
  logic driving_q, driving_d;
  logic fault_q, fault_d;

  logic tick;
  logic cur_pol;
  logic pwm_on;

  // Free-running millisecond prescaler; tick is high for one cycle per ms.
  always_comb begin
    tick = (ms_q == MS_LAST);
    ms_d = tick ? '0 : ms_q + 1'b1;
  end

  // Next-state logic. Priority inside a drive state:
  // watchdog fault > scan_active low > polarity change.
  // In DEAD: scan_active low > polarity change > dead-count expiry.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    dead_d   = dead_q;
    amp_d    = amp_q;
    pre_d    = pre_q;
    slot_d   = slot_q;
    hold_d   = hold_q;
    cur_pol  = (state_q == DRIVE_POS);

    case (state_q)
      IDLE: begin
        hold_d = '0;
        // Amplitude is only accepted while the bridge is idle so the
        // duty cycle never changes in the middle of a scan.
        if (bus.meta_valid) begin
          amp_d = bus.meta;
        end
        if (bus.scan_active) begin
          state_d  = DEAD;
          target_d = bus.polarity;
          dead_d   = '0;
        end
      end

      DEAD: begin
        hold_d = '0;
        if (!bus.scan_active) begin
          state_d = IDLE;
        end else if (bus.polarity != target_q) begin
          // A new request restarts the full dead time.
          target_d = bus.polarity;
          dead_d   = '0;
        end else if (dead_q == DEAD_LAST) begin
          state_d = target_q ? DRIVE_POS : DRIVE_NEG;
          pre_d   = '0;
          slot_d  = '0;
        end else begin
          dead_d = dead_q + 1'b1;
        end
      end

      DRIVE_POS, DRIVE_NEG: begin
        if (tick && (hold_q == HOLD_LAST)) begin
          state_d = FAULT;
          hold_d  = hold_q + 1'b1;
        end else if (!bus.scan_active) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (bus.polarity != cur_pol) begin
          state_d  = DEAD;
          target_d = bus.polarity;
          dead_d   = '0;
          hold_d   = '0;
        end else begin
          if (tick) begin
            hold_d = hold_q + 1'b1;
          end
          // PWM slot advances once per PWM_DIV cycles and wraps 15 -> 0.
          if (pre_q == PRE_LAST) begin
            pre_d  = '0;
            slot_d = slot_q + 4'd1;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
      end

      FAULT: begin
        // Sticky until reset; scan_active and polarity are ignored.
        state_d = FAULT;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Gate decode from the next state so gates and state change on the
  // same edge: no gate is ever on while the state register is not a
  // drive state, and each leg only ever has one device enabled.
  always_comb begin
    hs_a_d    = 1'b0;
    ls_a_d    = 1'b0;
    hs_b_d    = 1'b0;
    ls_b_d    = 1'b0;
    driving_d = 1'b0;
    fault_d   = 1'b0;
    pwm_on    = (slot_d < amp_q);

    case (state_d)
      DRIVE_POS: begin
        ls_b_d    = 1'b1;
        hs_a_d    = pwm_on;
        driving_d = 1'b1;
      end
      DRIVE_NEG: begin
        ls_a_d    = 1'b1;
        hs_b_d    = pwm_on;
        driving_d = 1'b1;
      end
      FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        hs_a_d = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK_IN) begin
    if (rst) begin
      state_q   <= IDLE;
      target_q  <= 1'b0;
      dead_q    <= '0;
      amp_q     <= '0;
      pre_q     <= '0;
      slot_q    <= '0;
      ms_q      <= '0;
      hold_q    <= '0;
      hs_a_q    <= 1'b0;
      ls_a_q    <= 1'b0;
      hs_b_q    <= 1'b0;
      ls_b_q    <= 1'b0;
      driving_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      dead_q    <= dead_d;
      amp_q     <= amp_d;
      pre_q     <= pre_d;
      slot_q    <= slot_d;
      ms_q      <= ms_d;
      hold_q    <= hold_d;
      hs_a_q    <= hs_a_d;
      ls_a_q    <= ls_a_d;
      hs_b_q    <= hs_b_d;
      ls_b_q    <= ls_b_d;
      driving_q <= driving_d;
      fault_q   <= fault_d;
    end
  end

  assign bus.HS_A      = hs_a_q;
  assign bus.LS_A      = ls_a_q;
  assign bus.HS_B      = hs_b_q;
  assign bus.LS_B      = ls_b_q;
  assign bus.driving   = driving_q;
  assign bus.fault     = fault_q;
  assign bus.state_dbg = state_q;

endmodule

// File: doc/coil_driver.md
Name: coil_driver

Overview:
- H-bridge gate controller for the scan-loop coil.
- Sits directly downstream of the edge-protocol decoder FSM and consumes three things from it:
  - the 4-bit metadata word, used as the drive amplitude code;
  - a scan-active flag;
  - the positive/negative polarity request that toggles each scan edge.
- Produces shoot-through-safe gate drives with:
  - dead time between polarity changes;
  - PWM amplitude set by the metadata code;
  - a max-hold watchdog that latches a fault if polarity stops toggling.

Parameters:
- DEAD_CYC, 20: all-gates-off cycles inserted before any drive phase.
- PWM_DIV, 4: CLK_IN cycles per PWM slot; 16 slots per PWM period.
- TICKS_PER_MS, 10000: CLK_IN cycles per millisecond tick.
- MAX_HOLD_MS, 50: max ms in one drive polarity before fault.

Ports:
- CLK_IN  input  1  system clock
- rst  input  1  synchronous active-high reset
- scan_active  input  1  high while decoder is in a scan state (SendPos/SendNeg)
- polarity  input  1  1 = positive current requested, 0 = negative; valid only while scan_active
- meta  input  4  amplitude code from decoder
- meta_valid  input  1  one-cycle strobe, meta valid
- HS_A  output  1  high-side gate, leg A
- LS_A  output  1  low-side gate, leg A
- HS_B  output  1  high-side gate, leg B
- LS_B  output  1  low-side gate, leg B
- driving  output  1  high in DRIVE_POS/DRIVE_NEG
- fault  output  1  latched watchdog fault

Behaviour:
- Reset and clocking
  - Reset is synchronous, active-high, on CLK_IN.
  - On reset: state IDLE; all gates 0; driving 0; fault 0; amp register 0; all counters 0.
- Outputs
  - All outputs are registered. Gates reflect the state decided at edge N from edge N+1 onward.
- Amplitude capture
  - amp <= meta on meta_valid only in IDLE; meta_valid in any other state is ignored.
- States: IDLE, DEAD, DRIVE_POS, DRIVE_NEG, FAULT.
- IDLE
  - Gates off.
  - scan_active=1 -> DEAD, with target <= polarity and dead counter <= 0.
- DEAD
  - Gates off. Counter increments each cycle.
  - After exactly DEAD_CYC cycles in DEAD -> DRIVE_POS if target=1, else DRIVE_NEG.
  - If polarity changes while in DEAD: target updated, dead counter restarted at 0.
- DRIVE_POS
  - LS_B=1 continuously; HS_A=pwm_on; HS_A=0 and LS_A=0 otherwise.
- DRIVE_NEG
  - Mirror of DRIVE_POS: LS_A=1 continuously; HS_B=pwm_on; HS_A=0 and LS_B=0 otherwise.
- Polarity change while driving
  - Polarity differing from the current drive -> DEAD (gates off next cycle) with the new target.
- PWM
  - Slot prescaler counts 0..PWM_DIV-1; the 4-bit slot counter advances on prescaler wrap and wraps 15->0.
  - Both reset to 0 on entry to a DRIVE state.
  - pwm_on = (slot < amp).
  - amp=0: high side never on.
  - amp=15: on for 15 of 16 slots.
  - Low side stays on across off-slots (slow decay).
- Watchdog
  - Free-running ms prescaler (0..TICKS_PER_MS-1) emits a one-cycle tick.
  - Hold counter is cleared on every entry to DEAD or IDLE and increments on tick while in DRIVE_*.
  - Hold counter reaching MAX_HOLD_MS -> FAULT.
- FAULT
  - Gates off; fault=1.
  - Sticky: only rst exits; scan_active and polarity are ignored.
- scan_active falling
  - From DEAD or DRIVE_* -> IDLE, gates off next cycle; no dead time needed.
- Priority
  - Priority order: rst > watchdog fault > scan_active=0 > polarity change > dead-count expiry.
- Invariants, every cycle
  - Never (HS_A & LS_A) or (HS_B & LS_B).
  - Never any gate on in IDLE, DEAD or FAULT.
- driving output
  - driving=1 exactly when the registered state is DRIVE_POS or DRIVE_NEG.
- Counter widths
  - Counters are sized with $clog2 of their parameter+1.
  - No counter may overflow before its terminal compare.

Test Plan:
- Reset; meta_valid with meta=4'hA; scan_active=1, polarity=1 -> gates 0 for 20 cycles, then LS_B=1, HS_A high for 40 of every 64 cycles, driving=1.
- While in DRIVE_POS, drop polarity to 0 -> next cycle all gates 0; 20 cycles later LS_A=1, HS_B PWM at the same duty; HS_A/LS_B stay 0 throughout.
- Toggle polarity every 5 cycles during DEAD -> dead count restarts each time; no gate asserts until 20 quiet cycles pass.
- amp=0 and amp=15 runs -> HS never high for amp=0; HS low only in slot 15 (4 cycles per 64) for amp=15; LS steady in both.
- Hold polarity=1 with TICKS_PER_MS=10, MAX_HOLD_MS=3 -> fault=1 and all gates 0 at about 30 cycles into drive; toggling inputs is ignored; rst clears fault.
- Assert rst mid-DRIVE_NEG -> next edge all outputs 0, state IDLE; meta_valid sent during DRIVE is not captured (amp unchanged); a shoot-through assertion runs in all tests.
